// File: rtl/ahb3lite_pkg.sv
// AHB-Lite encodings and the DMA read master state type shared by the
// read master and its testbench.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_INCR = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      BURST,
      LAST,
      DONE,
      ERR
   } dma_rd_state_t;

endpackage

// File: rtl/dma_rd_fifo.sv
// Read-data FIFO between the AHB data phase and the downstream consumer.
// Pointers carry one extra bit so full and empty are told apart without a flag.
module dma_rd_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 32
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_CNT = FIFO_DEPTH[PW:0];

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign count     = wr_ptr - rd_ptr;
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_CNT);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
   end

   // The master's credit check must make a push into a full FIFO impossible.
   no_overflow: assert property (@(posedge HCLK) disable iff (HRESET)
      !(push && full && !do_pop));

endmodule

// File: rtl/ahb_dma_read_master.sv
// AHB-Lite INCR word-read master executing one DMA read command at a time;
// read data is streamed through dma_rd_fifo toward the consumer.
module ahb_dma_read_master
   import ahb3lite_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        NewCommandOn,
   input  logic [5:0]  i_RCC_BUFFER_LENGTH,
   input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
   input  logic [15:0] i_RCC_DMA_ADDR_LOW,
   output logic        Master_Done,
   output logic        o_error,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HBURST,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic [31:0] o_rd_data,
   output logic        o_rd_valid,
   input  logic        i_rd_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

   dma_rd_state_t state, state_next;
   logic          cmd_q;
   logic          accept;
   logic [1:0]    htrans_q, htrans_next;
   logic [31:0]   haddr_q, haddr_next;
   logic [31:0]   next_addr;
   logic [5:0]    remaining, remaining_next;
   logic [5:0]    rem_after;
   logic          dphase_q, dphase_next;
   logic          error_q, error_next;
   logic          addr_active;
   logic          beat_accepted;
   logic          first_beat;
   logic          err_first, err_last;
   logic          push, pop;
   logic          fifo_full, fifo_empty;
   logic [PW:0]   fifo_count;
   logic [CW:0]   committed;
   logic          credit_ok;

   assign accept        = (state == IDLE) && NewCommandOn && !cmd_q;
   assign addr_active   = htrans_q[1];
   assign beat_accepted = HREADY && addr_active;
   assign rem_after     = remaining - {5'b0, beat_accepted};
   assign next_addr     = beat_accepted ? haddr_q + 32'd4 : haddr_q;
   assign first_beat    = (state == ADDR) && !beat_accepted;
   assign err_first     = dphase_q && HRESP && !HREADY;
   assign err_last      = dphase_q && HRESP && HREADY;
   assign push          = dphase_q && HREADY && !HRESP;
   assign pop           = i_rd_ready;

   // Entries already owed: stored words, the word landing this cycle and the
   // beat moving into its data phase; pops are ignored to stay conservative.
   assign committed = {1'b0, fifo_count} + {{CW{1'b0}}, push} + {{CW{1'b0}}, addr_active};
   assign credit_ok = !fifo_full && (committed < DEPTH_W);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= IDLE;
         cmd_q     <= 1'b0;
         htrans_q  <= HTRANS_IDLE;
         haddr_q   <= '0;
         remaining <= '0;
         dphase_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state     <= state_next;
         cmd_q     <= NewCommandOn;
         htrans_q  <= htrans_next;
         haddr_q   <= haddr_next;
         remaining <= remaining_next;
         dphase_q  <= dphase_next;
         error_q   <= error_next;
      end
   end

   // Address phase of beat n+1 overlaps data phase of beat n; the address
   // side only moves on HREADY except when an error response cancels it.
   always_comb begin
      state_next     = state;
      htrans_next    = htrans_q;
      haddr_next     = next_addr;
      remaining_next = rem_after;
      dphase_next    = HREADY ? addr_active : dphase_q;
      error_next     = error_q;
      case (state)
         IDLE: begin
            if (accept) begin
               error_next     = 1'b0;
               haddr_next     = {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW} & 32'hFFFF_FFFC;
               remaining_next = i_RCC_BUFFER_LENGTH;
               if (i_RCC_BUFFER_LENGTH == 6'd0) begin
                  state_next = DONE;
               end else begin
                  state_next = ADDR;
                  if (HREADY && credit_ok) htrans_next = HTRANS_NONSEQ;
               end
            end
         end
         ADDR, BURST, LAST: begin
            if (err_first) begin
               htrans_next = HTRANS_IDLE;
            end else if (err_last) begin
               htrans_next = HTRANS_IDLE;
               dphase_next = 1'b0;
               error_next  = 1'b1;
               state_next  = ERR;
            end else if (HREADY) begin
               if (state == LAST) begin
                  state_next = DONE;
               end else if (rem_after == 6'd0) begin
                  htrans_next = HTRANS_IDLE;
                  state_next  = LAST;
               end else begin
                  if (state == ADDR && beat_accepted) state_next = BURST;
                  if (credit_ok) begin
                     htrans_next = (first_beat || next_addr[9:0] == 10'd0) ? HTRANS_NONSEQ
                                                                           : HTRANS_SEQ;
                  end else begin
                     htrans_next = first_beat ? HTRANS_IDLE : HTRANS_BUSY;
                  end
               end
            end
         end
         DONE: state_next = IDLE;
         ERR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   dma_rd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (32)
   ) u_fifo (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .push      (push),
      .push_data (HRDATA),
      .pop       (pop),
      .head_data (o_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign o_rd_valid  = !fifo_empty;
   assign Master_Done = (state == DONE) || (state == ERR);
   assign o_error     = error_q;
   assign HADDR       = haddr_q;
   assign HTRANS      = htrans_q;
   assign HBURST      = HBURST_INCR;
   assign HSIZE       = HSIZE_WORD;
   assign HWRITE      = 1'b0;
   assign HPROT       = HPROT_VAL;
   assign HMASTLOCK   = 1'b0;

endmodule

// File: tb/tb_ahb_dma_read_master.sv
// Directed bench for ahb_dma_read_master: a cycle table for a plain burst,
// then hand-written sequences for boundary, wait-state, error and back-pressure cases.
module tb_ahb_dma_read_master;
   import ahb3lite_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        NewCommandOn;
   logic [5:0]  i_RCC_BUFFER_LENGTH;
   logic [15:0] i_RCC_DMA_ADDR_HIGH;
   logic [15:0] i_RCC_DMA_ADDR_LOW;
   logic        Master_Done;
   logic        o_error;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HBURST;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] o_rd_data;
   logic        o_rd_valid;
   logic        i_rd_ready;

   int checks = 0;
   int errors = 0;

   // Slave model: read data is the beat address XORed with KEY.
   logic [31:0] apAddr = '0;
   logic        apReady = 1'b0;
   logic [31:0] dpAddr = '0;
   logic [31:0] popQ[$];
   logic [33:0] acceptQ[$];
   int          mdCount = 0;
   int          busyCount = 0;
   int          nonIdleCount = 0;

   typedef struct {
      logic        cmd;
      logic [1:0]  expTrans;
      logic        chkAddr;
      logic [31:0] expAddr;
      logic        expDone;
      logic        expValid;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[8];

   ahb_dma_read_master #(
      .FIFO_DEPTH (4),
      .HPROT_VAL  (4'b0011)
   ) dut (
      .HCLK                (HCLK),
      .HRESET              (HRESET),
      .NewCommandOn        (NewCommandOn),
      .i_RCC_BUFFER_LENGTH (i_RCC_BUFFER_LENGTH),
      .i_RCC_DMA_ADDR_HIGH (i_RCC_DMA_ADDR_HIGH),
      .i_RCC_DMA_ADDR_LOW  (i_RCC_DMA_ADDR_LOW),
      .Master_Done         (Master_Done),
      .o_error             (o_error),
      .HADDR               (HADDR),
      .HTRANS              (HTRANS),
      .HBURST              (HBURST),
      .HSIZE               (HSIZE),
      .HWRITE              (HWRITE),
      .HPROT               (HPROT),
      .HMASTLOCK           (HMASTLOCK),
      .HRDATA              (HRDATA),
      .HREADY              (HREADY),
      .HRESP               (HRESP),
      .o_rd_data           (o_rd_data),
      .o_rd_valid          (o_rd_valid),
      .i_rd_ready          (i_rd_ready)
   );

   always #5 HCLK = ~HCLK;

   assign HRDATA = dpAddr ^ KEY;

   // Bus and consumer observation happens mid-cycle, away from the rising edge.
   always @(negedge HCLK) begin
      apAddr  = HADDR;
      apReady = HREADY;
      if (!HRESET) begin
         if (HREADY && HTRANS[1]) acceptQ.push_back({HTRANS, HADDR});
         if (o_rd_valid && i_rd_ready) popQ.push_back(o_rd_data);
         if (Master_Done) mdCount++;
         if (HTRANS == HTRANS_BUSY) busyCount++;
         if (HTRANS != HTRANS_IDLE) nonIdleCount++;
      end
   end

   always @(posedge HCLK) begin
      if (apReady) dpAddr <= apAddr;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [5:0] len);
      @(posedge HCLK);
      #1;
      acceptQ.delete();
      popQ.delete();
      mdCount      = 0;
      busyCount    = 0;
      nonIdleCount = 0;
      i_RCC_DMA_ADDR_HIGH = addr[31:16];
      i_RCC_DMA_ADDR_LOW  = addr[15:0];
      i_RCC_BUFFER_LENGTH = len;
      NewCommandOn        = 1'b1;
      @(posedge HCLK);
      #1;
      NewCommandOn = 1'b0;
   endtask

   task automatic waitDone(input string name, input int maxCycles);
      int n = 0;
      while (mdCount == 0 && n < maxCycles) begin
         tick(1);
         n++;
      end
      checks++;
      if (mdCount == 0) begin
         errors++;
         $display("[TB] FAIL %s: Master_Done not seen within %0d cycles", name, maxCycles);
      end
   endtask

   task automatic checkBeats(input string name, input logic [31:0] base, input int n);
      checkOutput({name, " word count"}, popQ.size(), n);
      for (int i = 0; i < n && i < popQ.size(); i++)
         checkOutput($sformatf("%s word%0d", name, i), popQ[i], (base + 32'(4 * i)) ^ KEY);
   endtask

   initial begin
      logic [33:0] bndExp[4];
      int          n;

      HRESET = 1'b1;
      NewCommandOn = 1'b0;
      i_RCC_BUFFER_LENGTH = '0;
      i_RCC_DMA_ADDR_HIGH = '0;
      i_RCC_DMA_ADDR_LOW  = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      i_rd_ready = 1'b1;
      tick(3);
      HRESET = 1'b0;

      checkOutput("reset o_error", o_error, 1'b0);
      checkOutput("constant HBURST", HBURST, HBURST_INCR);
      checkOutput("constant HSIZE", HSIZE, HSIZE_WORD);
      checkOutput("constant HPROT", HPROT, 4'b0011);

      // Four-beat burst at 0x1000, zero wait states, consumer always ready.
      i_RCC_DMA_ADDR_HIGH = 16'h0000;
      i_RCC_DMA_ADDR_LOW  = 16'h1000;
      i_RCC_BUFFER_LENGTH = 6'd4;
      vecs[0] = '{1'b1, HTRANS_IDLE,   1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b1, HTRANS_NONSEQ, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{1'b1, HTRANS_SEQ,    1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{1'b1, HTRANS_SEQ,    1'b1, 32'h0000_1008, 1'b0, 1'b1, 32'hA5A5_1000};
      vecs[4] = '{1'b1, HTRANS_SEQ,    1'b1, 32'h0000_100C, 1'b0, 1'b1, 32'hA5A5_1004};
      vecs[5] = '{1'b1, HTRANS_IDLE,   1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_1008};
      vecs[6] = '{1'b0, HTRANS_IDLE,   1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_100C};
      vecs[7] = '{1'b0, HTRANS_IDLE,   1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         @(posedge HCLK);
         #1;
         NewCommandOn = vecs[i].cmd;
         @(negedge HCLK);
         checkOutput($sformatf("vec%0d HTRANS", i), HTRANS, vecs[i].expTrans);
         if (vecs[i].chkAddr)
            checkOutput($sformatf("vec%0d HADDR", i), HADDR, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d Master_Done", i), Master_Done, vecs[i].expDone);
         checkOutput($sformatf("vec%0d o_rd_valid", i), o_rd_valid, vecs[i].expValid);
         if (vecs[i].expValid)
            checkOutput($sformatf("vec%0d o_rd_data", i), o_rd_data, vecs[i].expData);
      end

      // Zero-length command: completion pulse only, no bus activity.
      $display("[TB] zero-length command");
      applyStimulus(32'hDEAD_BEE0, 6'd0);
      waitDone("len0 done", 10);
      tick(3);
      checkOutput("len0 done pulses", mdCount, 1);
      checkOutput("len0 non-idle cycles", nonIdleCount, 0);
      checkOutput("len0 o_error", o_error, 1'b0);
      checkOutput("len0 o_rd_valid", o_rd_valid, 1'b0);

      // 1KB boundary crossing restarts the burst with NONSEQ at 0x400.
      $display("[TB] 1KB boundary burst");
      applyStimulus(32'h0000_03F8, 6'd4);
      waitDone("boundary done", 40);
      tick(2);
      bndExp[0] = {HTRANS_NONSEQ, 32'h0000_03F8};
      bndExp[1] = {HTRANS_SEQ,    32'h0000_03FC};
      bndExp[2] = {HTRANS_NONSEQ, 32'h0000_0400};
      bndExp[3] = {HTRANS_SEQ,    32'h0000_0404};
      checkOutput("boundary beat count", acceptQ.size(), 4);
      for (int i = 0; i < 4 && i < acceptQ.size(); i++) begin
         checkOutput($sformatf("boundary beat%0d HTRANS", i), 32'(acceptQ[i][33:32]), 32'(bndExp[i][33:32]));
         checkOutput($sformatf("boundary beat%0d HADDR", i), acceptQ[i][31:0], bndExp[i][31:0]);
      end
      checkBeats("boundary", 32'h0000_03F8, 4);

      // Three wait states in the data phase of beat 2 of 6.
      $display("[TB] wait states on beat 2");
      applyStimulus(32'h0000_5000, 6'd6);
      n = 0;
      while (acceptQ.size() < 2 && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput("wait reached beat 2", acceptQ.size(), 2);
      HREADY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge HCLK);
         checkOutput($sformatf("wait%0d HTRANS held", k), HTRANS, HTRANS_SEQ);
         checkOutput($sformatf("wait%0d HADDR held", k), HADDR, 32'h0000_5008);
         tick(1);
      end
      HREADY = 1'b1;
      waitDone("wait done", 40);
      tick(2);
      checkOutput("wait beat count", acceptQ.size(), 6);
      checkBeats("wait", 32'h0000_5000, 6);
      checkOutput("wait done pulses", mdCount, 1);

      // ERROR response on beat 3 of 8 with the consumer stalled.
      $display("[TB] error response on beat 3");
      i_rd_ready = 1'b0;
      applyStimulus(32'h0000_2000, 6'd8);
      n = 0;
      while (acceptQ.size() < 3 && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput("err reached beat 3", acceptQ.size(), 3);
      HRESP  = 1'b1;
      HREADY = 1'b0;
      @(negedge HCLK);
      checkOutput("err pending HADDR", HADDR, 32'h0000_200C);
      tick(1);
      HREADY = 1'b1;
      @(negedge HCLK);
      checkOutput("err second cycle HTRANS", HTRANS, HTRANS_IDLE);
      tick(1);
      HRESP = 1'b0;
      @(negedge HCLK);
      checkOutput("err Master_Done", Master_Done, 1'b1);
      checkOutput("err o_error", o_error, 1'b1);
      tick(1);
      @(negedge HCLK);
      checkOutput("err Master_Done single", Master_Done, 1'b0);
      checkOutput("err o_error sticky", o_error, 1'b1);
      checkOutput("err o_rd_valid", o_rd_valid, 1'b1);
      checkOutput("err accepted beats", acceptQ.size(), 3);
      tick(1);
      i_rd_ready = 1'b1;
      tick(8);
      checkBeats("err", 32'h0000_2000, 2);
      checkOutput("err done pulses", mdCount, 1);

      // Consumer stalled: FIFO fills to depth, master drives BUSY, then resumes.
      $display("[TB] back-pressure burst");
      i_rd_ready = 1'b0;
      applyStimulus(32'h0000_3000, 6'd8);
      checkOutput("bp o_error cleared", o_error, 1'b0);
      tick(15);
      checkOutput("bp beats before release", acceptQ.size(), 4);
      checkOutput("bp BUSY seen", 32'(busyCount > 0), 1);
      checkOutput("bp HTRANS stalled", HTRANS, HTRANS_BUSY);
      checkOutput("bp o_rd_valid", o_rd_valid, 1'b1);
      checkOutput("bp no early done", mdCount, 0);
      i_rd_ready = 1'b1;
      waitDone("bp done", 80);
      tick(3);
      checkOutput("bp total beats", acceptQ.size(), 8);
      checkBeats("bp", 32'h0000_3000, 8);
      checkOutput("bp done pulses", mdCount, 1);

      // Reset in the middle of a burst aborts it without a completion pulse.
      $display("[TB] reset mid-burst");
      applyStimulus(32'h0000_6000, 6'd8);
      tick(2);
      HRESET = 1'b1;
      @(negedge HCLK);
      checkOutput("rst HTRANS", HTRANS, HTRANS_IDLE);
      checkOutput("rst HADDR", HADDR, 32'h0);
      checkOutput("rst o_rd_valid", o_rd_valid, 1'b0);
      checkOutput("rst Master_Done", Master_Done, 1'b0);
      tick(1);
      HRESET = 1'b0;
      tick(5);
      checkOutput("rst no done pulse", mdCount, 0);
      checkOutput("rst idle after", HTRANS, HTRANS_IDLE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_dma_read_master.md
Name: ahb_dma_read_master

Overview:
AHB-Lite read master that executes one DMA read command at a time. It consumes the latched command from the CPU register stage: start level, 32-bit start address from the HIGH/LOW halves, and a 6-bit word count. It issues an INCR word-read burst on the AHB-Lite bus and streams the read data into a small FIFO toward the downstream consumer. On completion or error it pulses Master_Done back to the register stage.

Parameters:
FIFO_DEPTH, 4, read-data FIFO entries (power of 2, >=2)
HPROT_VAL, 4'b0011, constant HPROT driven on every transfer

Ports:
HCLK  input  1  bus clock, all logic rising-edge
HRESET  input  1  asynchronous active-high reset
NewCommandOn  input  1  command-active level from register stage
i_RCC_BUFFER_LENGTH  input  6  words to read (0..63)
i_RCC_DMA_ADDR_HIGH  input  16  start address [31:16]
i_RCC_DMA_ADDR_LOW  input  16  start address [15:0]
Master_Done  output  1  one-cycle completion pulse
o_error  output  1  sticky error flag; cleared at next accepted command
HADDR  output  32  AHB address
HTRANS  output  2  AHB transfer type
HBURST  output  3  constant INCR (3'b001)
HSIZE  output  3  constant word (3'b010)
HWRITE  output  1  constant 0
HPROT  output  4  HPROT_VAL
HMASTLOCK  output  1  constant 0
HRDATA  input  32  read data
HREADY  input  1  transfer done / wait state
HRESP  input  1  0 OKAY, 1 ERROR
o_rd_data  output  32  FIFO head data
o_rd_valid  output  1  FIFO non-empty
i_rd_ready  input  1  consumer pops when valid && ready

Behaviour:
- Reset (async, HRESET=1): state IDLE; HTRANS=IDLE, HADDR=0, Master_Done=0, o_error=0, FIFO flushed, o_rd_valid=0. Reset mid-burst aborts the burst with no completion pulse.
- Command accept: a rising edge of NewCommandOn (registered previous value) seen in IDLE. Address and length are captured the same cycle. The start address is {HIGH,LOW} with bits [1:0] forced to 0. o_error is cleared. Edges outside IDLE are ignored.
- Length 0: go to DONE; Master_Done pulses the next cycle; no bus transfer.
- States:
  - IDLE -> ADDR on accept.
  - ADDR -> BURST after the first NONSEQ is accepted (HREADY=1).
  - BURST issues the remaining beats.
  - LAST -> DONE once the final data phase completes.
  - DONE pulses Master_Done for one cycle, then -> IDLE.
  - Any state -> ERR on error. ERR pulses Master_Done, sets o_error, then -> IDLE.
- Pipelining: the address phase of beat n+1 overlaps the data phase of beat n. HADDR/HTRANS advance only when HREADY=1 and are held stable while HREADY=0.
- HTRANS:
  - First beat: NONSEQ.
  - Following beats: SEQ, except NONSEQ when HADDR[9:0]==0 (1KB boundary restart).
  - After the last beat: IDLE.
- Address: +4 per accepted beat, modulo 2^32 (wraps 0xFFFF_FFFC -> 0).
- Flow control: a beat's address is issued only if FIFO free entries > beats in data phase (max 1). Otherwise drive BUSY mid-burst, or hold IDLE before the first beat. BUSY is never driven after the last beat.
- Data: HRDATA is pushed into the FIFO on every data-phase cycle with HREADY=1 and HRESP=0. Push and pop in the same cycle are allowed when full or empty. The credit rule guarantees no overflow; overflow is an assertion failure.
- Error (two-cycle AHB-Lite response):
  - First cycle (HRESP=1, HREADY=0): drive HTRANS=IDLE next cycle, cancelling the pending address phase.
  - Second cycle (HRESP=1, HREADY=1): enter ERR.
  - Errored data is not pushed. Already-pushed data stays in the FIFO.
- Master_Done is high for exactly one cycle per accepted command.

Decomposition:
- ahb3lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_INCR, HSIZE_WORD constants, and a typedef enum for dma_rd_state_t {IDLE, ADDR, BURST, LAST, DONE, ERR}.
- Sub-module dma_rd_fifo: synchronous FIFO with FIFO_DEPTH entries, ptr+1-bit occupancy, outputs full/empty/count, reset by HRESET.

Test Plan:
- Addr 0x0000_1000, len 4, HREADY=1, ready=1 -> HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE; HADDR 0x1000..0x100C; 4 words out in order; Master_Done pulses 1 cycle after the last data phase.
- Len 0, addr 0xDEAD_BEE0 -> no non-IDLE HTRANS; Master_Done pulses once; o_error=0.
- Addr 0x0000_03F8, len 4 -> beat at 0x400 is NONSEQ; sequence NONSEQ,SEQ,NONSEQ,SEQ.
- HREADY low for 3 cycles on beat 2 of 6 -> HADDR/HTRANS held stable; all 6 words correct.
- HRESP error on beat 3 of 8 at 0x2000 -> HTRANS=IDLE the cycle after the first error cycle; o_error=1; Master_Done pulse; FIFO holds 2 words.
- i_rd_ready=0, len 8, FIFO_DEPTH=4 -> exactly 4 words buffered, BUSY driven, no overflow; releasing ready completes all 8 beats.
